// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter (optional DMEM_ARB_RR_EN)
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_e;

    localparam int WORD_BYTES = 4;
    localparam int OFS_W      = $clog2(WORD_BYTES);

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection, round-robin ties when DMEM_ARB_RR_EN is defined
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  owner_e last_owner,
    output owner_e winner
);

    owner_e tie_winner;

    // On a tie round-robin hands the grant to whoever did not win last; fixed priority always picks cpu
    always_comb begin
        tie_winner = (RR_EN && last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
        winner     = (cpu_req && dbg_req) ? tie_winner : (cpu_req ? OWN_CPU : OWN_DBG);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester word arbiter for a small data memory, one access per 3 cycles (DMEM_ARB_RR_EN selects round-robin ties)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    output logic                cpu_gnt,
    output logic                cpu_done,
    output logic                cpu_err,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                dbg_gnt,
    output logic                dbg_done,
    output logic                dbg_err,
    output logic [DATA_W-1:0]   dbg_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_owner_q, last_owner_d;
    owner_e              winner;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                misaligned;

    assign misaligned = addr_q[OFS_W-1:0] != '0;

    dmem_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .last_owner (last_owner_q),
        .winner     (winner)
    );

    // State and latched-request registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_DBG;
            last_owner_q <= OWN_DBG;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Next state: grant and latch in IDLE, one memory cycle in ACCESS, capture read data in RESP
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        case (state_q)
            IDLE: if (cpu_req || dbg_req) begin
                state_d      = ACCESS;
                owner_d      = winner;
                last_owner_d = winner;
                we_d         = (winner == OWN_CPU) ? cpu_we    : dbg_we;
                addr_d       = (winner == OWN_CPU) ? cpu_addr  : dbg_addr;
                wdata_d      = (winner == OWN_CPU) ? cpu_wdata : dbg_wdata;
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                if (!we_q && !misaligned) begin
                    if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
                    else                    dbg_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; gnt is also held low while reset is asserted
    always_comb begin
        cpu_gnt   = rst_n && state_q == IDLE && cpu_req && winner == OWN_CPU;
        dbg_gnt   = rst_n && state_q == IDLE && dbg_req && winner == OWN_DBG;
        mem_en    = state_q == ACCESS && !misaligned;
        mem_we    = mem_en && we_q;
        mem_addr  = (state_q == ACCESS) ? addr_q[ADDR_W-1:OFS_W] : '0;
        mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
        cpu_done  = state_q == RESP && owner_q == OWN_CPU;
        dbg_done  = state_q == RESP && owner_q == OWN_DBG;
        cpu_err   = cpu_done && misaligned;
        dbg_err   = dbg_done && misaligned;
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [4:0]  cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata, mem_rdata;
    logic        cpu_gnt, cpu_done, cpu_err, dbg_gnt, dbg_done, dbg_err;
    logic [31:0] cpu_rdata, dbg_rdata, mem_wdata;
    logic        mem_en, mem_we;
    logic [2:0]  mem_addr;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_done  (dbg_done),
        .dbg_err   (dbg_err),
        .dbg_rdata (dbg_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        mem_rdata = 0;
        #3;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        step; rst_n = 1'b1;

        // dbg write 0xDEADBEEF to 0x08
        step; dbg_req = 1; dbg_we = 1; dbg_addr = 5'h08; dbg_wdata = 32'hDEADBEEF;
        #1;
        chk("w_dbg_gnt", dbg_gnt, 1);
        chk("w_cpu_gnt", cpu_gnt, 0);
        step; dbg_req = 0;
        chk("w_mem_en", mem_en, 1);
        chk("w_mem_we", mem_we, 1);
        chk("w_mem_addr", mem_addr, 2);
        chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
        step;
        chk("w_dbg_done", dbg_done, 1);
        chk("w_dbg_err", dbg_err, 0);
        chk("w_cpu_done", cpu_done, 0);
        chk("w_mem_en_resp", mem_en, 0);
        step;
        chk("w_dbg_done_idle", dbg_done, 0);

        // cpu read 0x08, dbg raised during RESP waits for IDLE
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h08;
        #1;
        chk("r_cpu_gnt", cpu_gnt, 1);
        step; cpu_req = 0; mem_rdata = 32'hDEADBEEF;
        chk("r_mem_en", mem_en, 1);
        chk("r_mem_we", mem_we, 0);
        chk("r_mem_addr", mem_addr, 2);
        step;
        chk("r_cpu_done", cpu_done, 1);
        chk("r_cpu_err", cpu_err, 0);
        chk("r_dbg_done", dbg_done, 0);
        dbg_req = 1; dbg_we = 0; dbg_addr = 5'h04;
        #1;
        chk("r_dbg_gnt_resp", dbg_gnt, 0);
        step;
        chk("r_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("r_cpu_done_idle", cpu_done, 0);
        chk("r_dbg_gnt_idle", dbg_gnt, 1);
        mem_rdata = 32'h12345678;
        step; dbg_req = 0;
        chk("r2_mem_addr", mem_addr, 1);
        chk("r2_dbg_gnt", dbg_gnt, 0);
        step;
        chk("r2_dbg_done", dbg_done, 1);
        chk("r2_cpu_done", cpu_done, 0);
        step;
        chk("r2_dbg_rdata", dbg_rdata, 32'h12345678);
        chk("r2_cpu_rdata_held", cpu_rdata, 32'hDEADBEEF);

        // misaligned cpu read 0x05
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h05; mem_rdata = 32'hFFFFFFFF;
        #1;
        chk("m_cpu_gnt", cpu_gnt, 1);
        step; cpu_req = 0;
        chk("m_mem_en", mem_en, 0);
        step;
        chk("m_cpu_done", cpu_done, 1);
        chk("m_cpu_err", cpu_err, 1);
        chk("m_dbg_err", dbg_err, 0);
        step;
        chk("m_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("m_cpu_err_idle", cpu_err, 0);

        // reset during ACCESS
        cpu_req = 1; cpu_we = 1; cpu_addr = 5'h0C; cpu_wdata = 32'h00000055;
        step; cpu_req = 0;
        chk("x_mem_en", mem_en, 1);
        rst_n = 1'b0;
        #1;
        chk("x_mem_en_rst", mem_en, 0);
        chk("x_mem_we_rst", mem_we, 0);
        chk("x_mem_addr_rst", mem_addr, 0);
        chk("x_mem_wdata_rst", mem_wdata, 0);
        chk("x_cpu_rdata_rst", cpu_rdata, 0);
        chk("x_dbg_rdata_rst", dbg_rdata, 0);
        step; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("x_no_cpu_done", cpu_done, 0);
            chk("x_no_mem_en", mem_en, 0);
        end
        dbg_req = 1; dbg_we = 0; dbg_addr = 5'h10; mem_rdata = 32'hA5A5A5A5;
        #1;
        chk("x_dbg_gnt", dbg_gnt, 1);
        step; dbg_req = 0;
        chk("x_mem_addr", mem_addr, 4);
        step;
        chk("x_dbg_done", dbg_done, 1);
        step;
        chk("x_dbg_rdata", dbg_rdata, 32'hA5A5A5A5);

        // both requesters held from reset
        rst_n = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h00;
        dbg_req = 1; dbg_we = 0; dbg_addr = 5'h00;
        #1;
        chk("t_gnt_in_rst", {cpu_gnt, dbg_gnt}, 0);
        step; rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            chk("t_cpu_gnt", cpu_gnt, (i % 2 == 0) ? 1 : 0);
            chk("t_dbg_gnt", dbg_gnt, (i % 2 == 0) ? 0 : 1);
`else
            chk("t_cpu_gnt", cpu_gnt, 1);
            chk("t_dbg_gnt", dbg_gnt, 0);
`endif
            step; step; step;
            #1;
        end
        cpu_req = 0; dbg_req = 0;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, byte-address width (32-byte data memory).
REQ-002 Parameter DATA_W, default 32, word width; the value is fixed at 32.
REQ-003 Port clk, input, 1, single clock; all state changes on posedge clk.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port cpu_req / dbg_req, input, 1 each, access request from the processor load/store path or the debug loader.
REQ-006 Port cpu_we / dbg_we, input, 1 each, 1 = word write, 0 = word read.
REQ-007 Port cpu_addr / dbg_addr, input, ADDR_W each, byte address.
REQ-008 Port cpu_wdata / dbg_wdata, input, 32 each, big-endian write word.
REQ-009 Port cpu_gnt / dbg_gnt, output, 1 each, one-cycle accept pulse.
REQ-010 Port cpu_done / dbg_done, output, 1 each, one-cycle completion pulse.
REQ-011 Port cpu_err / dbg_err, output, 1 each, misalignment flag, valid with done.
REQ-012 Port cpu_rdata / dbg_rdata, output, 32 each, read word, valid with done and held until that requester's next done.
REQ-013 Port mem_en, mem_we, output, 1 each, memory strobe and write enable.
REQ-014 Port mem_addr, output, ADDR_W-2, word index; mem_wdata, output, 32; mem_rdata, input, 32, valid one cycle after mem_en.

Function
REQ-015 FSM states are IDLE, ACCESS and RESP; the FSM SHALL process one access per 3 cycles.
REQ-016 In IDLE with any req high, the arbiter SHALL select a winner, pulse its gnt combinationally in that cycle, latch we/addr/wdata/owner and move to ACCESS.
REQ-017 In ACCESS, the arbiter SHALL drive mem_en=1, mem_we=latched we, mem_addr=addr[ADDR_W-1:2] and mem_wdata for exactly one cycle, then move to RESP.
REQ-018 In RESP, the arbiter SHALL pulse the owner's done, load the owner's rdata from mem_rdata on reads (rdata is unchanged on writes), and return to IDLE.
REQ-019 If the latched addr[1:0]!=0, ACCESS SHALL keep mem_en=0, and RESP SHALL pulse done with err=1 and leave rdata unchanged.
REQ-020 A requester holds req and its fields stable until gnt; dropping req before gnt withdraws the request with no side effect.
REQ-021 Requests arriving while the FSM is in ACCESS or RESP SHALL wait; gnt SHALL never pulse outside IDLE.
REQ-022 If only one req is high, that requester SHALL win.
REQ-023 A last_owner register, updated at each grant, SHALL record the most recent winner.
REQ-024 Only the owner's done/err SHALL pulse; the other requester's outputs SHALL stay 0/unchanged.

Reset
REQ-025 rst_n low SHALL force, immediately: state=IDLE, all gnt/done/err=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, cpu_rdata=dbg_rdata=0, last_owner=dbg.
REQ-026 Reset during ACCESS or RESP SHALL abandon the access, with no done pulse after release.

Configuration
REQ-027 Macro DMEM_ARB_RR_EN, when defined, SHALL resolve simultaneous requests round-robin: the requester not equal to last_owner wins, so cpu wins the first tie after reset.
REQ-028 Without DMEM_ARB_RR_EN, cpu SHALL always win ties (fixed priority); last_owner is still maintained.

Structure
REQ-029 A shared package dmem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the owner enum (OWN_CPU/OWN_DBG) and the constant WORD_BYTES=4.
REQ-030 One sub-module, dmem_arb_pick, SHALL hold the combinational winner selection (inputs: reqs and last_owner; output: winner).

Verification
REQ-031 dbg write addr 0x08, data 0xDEADBEEF -> dbg_gnt in cycle 0, mem_en/mem_we=1 with mem_addr=2 in cycle 1, dbg_done in cycle 2, err=0.
REQ-032 cpu read addr 0x08 with mem_rdata=0xDEADBEEF -> cpu_done 2 cycles after gnt, cpu_rdata=0xDEADBEEF and held afterwards.
REQ-033 cpu and dbg req both held from reset -> with RR_EN, grants cpu, dbg, cpu, dbg; without it, cpu repeatedly while cpu_req stays high.
REQ-034 cpu read addr 0x05 -> mem_en never asserted, cpu_done with cpu_err=1, cpu_rdata unchanged.
REQ-035 rst_n low during ACCESS -> all outputs 0 immediately, no done after release, and the next request completes normally.
REQ-036 dbg_req raised while a cpu access is in RESP -> dbg_gnt in the following IDLE cycle, never earlier.
